// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the F/D/E/M/W pipeline and pipeline_hazard_ctrl.
// Signals are level-valid every cycle; there is no valid/ready handshake on this bundle.
interface pipeline_hazard_ctrl_if #(
    parameter int RAW   = 4,
    parameter int CNT_W = 32
);
    logic [RAW-1:0]   RA1D, RA2D, RA1E, RA2E;
    logic [RAW-1:0]   WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW, MemToRegE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] StallCycles, FlushEvents;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemToRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  StallCycles, FlushEvents
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemToRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output StallCycles, FlushEvents
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding, load-use stall, branch flush and PC-write serialisation for the 5-stage pipeline.
// Optional performance counters are compiled in with the macro HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int RAW     = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        PC_WAIT   = 2'd2
    } state_e;

    localparam logic [1:0] LCNT_INIT = 2'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [1:0] lcnt_q, lcnt_d;
    logic       load_use;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       out_stall_f, out_stall_d, out_flush_d, out_flush_e;
    logic [1:0] fwd_a, fwd_b;
    logic       unused_pcsrc;

    function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] ra,
                                           input logic [RAW-1:0] wa_m, input logic rw_m,
                                           input logic [RAW-1:0] wa_w, input logic rw_w);
        if (rw_m && (ra == wa_m))      return 2'b10;
        else if (rw_w && (ra == wa_w)) return 2'b01;
        else                           return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(hz.RA1E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
    assign fwd_b = fwd_sel(hz.RA2E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);

    assign load_use = hz.MemToRegE & hz.RegWriteE &
                      ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));

    // Only the D and W ends of the PC-write chain steer the FSM.
    assign unused_pcsrc = &{1'b0, hz.PCSrcE, hz.PCSrcM};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            lcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        if (hz.BranchTakenE) begin
            state_d = RUN;
            lcnt_d  = 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.PCSrcD) begin
                        state_d = PC_WAIT;
                    end else if (load_use && (MEM_LAT > 1)) begin
                        state_d = LOAD_WAIT;
                        lcnt_d  = LCNT_INIT;
                    end
                end
                LOAD_WAIT: begin
                    lcnt_d = lcnt_q - 2'd1;
                    if (lcnt_q <= 2'd1) begin
                        state_d = RUN;
                        lcnt_d  = 2'd0;
                    end
                end
                PC_WAIT: begin
                    if (hz.PCSrcW) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    lcnt_d  = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        case (state_q)
            RUN: begin
                if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            LOAD_WAIT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            PC_WAIT: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end
            default: ;
        endcase
        // A taken branch squashes whatever is in F/D, so nothing may be held.
        if (hz.BranchTakenE) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (stall_d) begin
            flush_d = 1'b0;
        end
    end

    assign out_stall_f = reset & stall_f;
    assign out_stall_d = reset & stall_d;
    assign out_flush_d = reset & flush_d;
    assign out_flush_e = reset & flush_e;

    assign hz.StallF    = out_stall_f;
    assign hz.StallD    = out_stall_d;
    assign hz.FlushD    = out_flush_d;
    assign hz.FlushE    = out_flush_e;
    assign hz.ForwardAE = reset ? fwd_a : 2'b00;
    assign hz.ForwardBE = reset ? fwd_b : 2'b00;
    assign dbg_state_o  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((out_stall_f | out_stall_d) && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (hz.BranchTakenE && !(&flush_cnt_q))             flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCycles = stall_cnt_q;
    assign hz.FlushEvents = flush_cnt_q;
`else
    assign hz.StallCycles = {CNT_W{1'b0}};
    assign hz.FlushEvents = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (MEM_LAT = 1, 3, 4) share one stimulus stream.
module tb_pipeline_hazard_ctrl;
    localparam int W = 10;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LW  = 2'd1;
    localparam logic [1:0] S_PC  = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       rwe, rwm, rww, m2re, pcd, pce, pcm, pcw, bte;

    logic [W-1:0]  obs [3];
    logic [31:0]   stall_cnt [3];
    logic [31:0]   flush_cnt [3];
    logic [W-1:0]  exp_q[$];
    int            errors = 0;
    int            checks = 0;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        pipeline_hazard_ctrl_if #(.RAW(4), .CNT_W(32)) hif ();
        logic [1:0] dbg;
        assign hif.RA1D = ra1d;  assign hif.RA2D = ra2d;
        assign hif.RA1E = ra1e;  assign hif.RA2E = ra2e;
        assign hif.WA3E = wa3e;  assign hif.WA3M = wa3m;  assign hif.WA3W = wa3w;
        assign hif.RegWriteE = rwe;  assign hif.RegWriteM = rwm;  assign hif.RegWriteW = rww;
        assign hif.MemToRegE = m2re;
        assign hif.PCSrcD = pcd;  assign hif.PCSrcE = pce;
        assign hif.PCSrcM = pcm;  assign hif.PCSrcW = pcw;
        assign hif.BranchTakenE = bte;
        pipeline_hazard_ctrl #(.RAW(4), .MEM_LAT(LAT), .CNT_W(32)) u_dut (
            .clk         (clk),
            .reset       (rst_n),
            .hz          (hif),
            .dbg_state_o (dbg)
        );
        assign obs[g] = {dbg, hif.ForwardAE, hif.ForwardBE,
                         hif.StallF, hif.StallD, hif.FlushD, hif.FlushE};
        assign stall_cnt[g] = hif.StallCycles;
        assign flush_cnt[g] = hif.FlushEvents;
    end

    typedef struct {
        logic [3:0] ra1e, ra2e, wa3m, wa3w;
        logic       rwm, rww;
        logic [1:0] fa, fb;
    } fwd_vec_t;
    fwd_vec_t vecs [8];

    function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [1:0] fa, input logic [1:0] fb,
                                        input logic sf, input logic sd, input logic fd, input logic fe);
        return {st, fa, fb, sf, sd, fd, fe};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra, input logic [3:0] wm, input logic rm,
                                           input logic [3:0] ww, input logic rw);
        if (rm && (ra == wm))      return 2'b10;
        else if (rw && (ra == ww)) return 2'b01;
        else                       return 2'b00;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 4;
    endfunction

    task automatic clear_inputs();
        ra1d = '0; ra2d = '0; ra1e = '0; ra2e = '0;
        wa3e = '0; wa3m = '0; wa3w = '0;
        rwe = 0; rwm = 0; rww = 0; m2re = 0;
        pcd = 0; pce = 0; pcm = 0; pcw = 0; bte = 0;
    endtask

    task automatic set_load_use();
        m2re = 1; rwe = 1; wa3e = 4'd5; ra2d = 4'd5;
    endtask

    task automatic expect3(input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [W-1:0] e2);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
    endtask

    task automatic check_pop(input string name);
        logic [W-1:0] want;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s dut%0d: scoreboard empty, got %b", name, g, obs[g]);
                return;
            end
            want = exp_q.pop_front();
            if (obs[g] !== want) begin
                errors++;
                $display("FAIL %s MEM_LAT=%0d: got %b expected %b ({state,fa,fb,sF,sD,fD,fE})",
                         name, lat_of(g), obs[g], want);
            end
        end
    endtask

    task automatic cyc(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                       input logic [W-1:0] e2);
        expect3(e0, e1, e2);
        @(negedge clk);
        check_pop(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int g, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s MEM_LAT=%0d: got %0d expected %0d", name, lat_of(g), got, want);
        end
    endtask

    logic [W-1:0] idle, lu, lw, pcw_w, br_run, br_lw, br_pc;
    logic [31:0]  base [3];

    task automatic lu_seq(input string name);
        for (int g = 0; g < 3; g++) base[g] = stall_cnt[g];
        set_load_use();
        cyc({name, "_c0"}, lu, lu, lu);
        clear_inputs();
        cyc({name, "_c1"}, idle, lw, lw);
        cyc({name, "_c2"}, idle, lw, lw);
        cyc({name, "_c3"}, idle, idle, lw);
        cyc({name, "_c4"}, idle, idle, idle);
        for (int g = 0; g < 3; g++) begin
`ifdef HAZARD_PERF_CNT_EN
            check_val({name, "_stall_cnt"}, g, stall_cnt[g] - base[g], 32'(lat_of(g)));
`else
            check_val({name, "_stall_cnt"}, g, stall_cnt[g], 32'd0);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fa, fb;
        idle   = mk(S_RUN, 2'b00, 2'b00, 0, 0, 0, 0);
        lu     = mk(S_RUN, 2'b00, 2'b00, 1, 1, 0, 1);
        lw     = mk(S_LW,  2'b00, 2'b00, 1, 1, 0, 1);
        pcw_w  = mk(S_PC,  2'b00, 2'b00, 1, 0, 1, 0);
        br_run = mk(S_RUN, 2'b00, 2'b00, 0, 0, 1, 1);
        br_lw  = mk(S_LW,  2'b00, 2'b00, 0, 0, 1, 1);
        br_pc  = mk(S_PC,  2'b00, 2'b00, 0, 0, 1, 1);

        vecs[0] = '{4'd3,  4'd4,  4'd3,  4'd0,  1'b1, 1'b0, 2'b10, 2'b00};
        vecs[1] = '{4'd3,  4'd4,  4'd3,  4'd3,  1'b1, 1'b1, 2'b10, 2'b00};
        vecs[2] = '{4'd3,  4'd4,  4'd3,  4'd3,  1'b0, 1'b1, 2'b01, 2'b00};
        vecs[3] = '{4'd2,  4'd7,  4'd7,  4'd2,  1'b1, 1'b1, 2'b01, 2'b10};
        vecs[4] = '{4'd0,  4'd0,  4'd0,  4'd0,  1'b1, 1'b0, 2'b10, 2'b10};
        vecs[5] = '{4'd6,  4'd6,  4'd6,  4'd6,  1'b0, 1'b0, 2'b00, 2'b00};
        vecs[6] = '{4'd15, 4'd15, 4'd14, 4'd15, 1'b1, 1'b1, 2'b01, 2'b01};
        vecs[7] = '{4'd9,  4'd9,  4'd9,  4'd9,  1'b1, 1'b1, 2'b10, 2'b10};

        // Reset with a live forwarding condition and a load-use present.
        clear_inputs();
        rwm = 1; wa3m = 4'd3; ra1e = 4'd3; ra2e = 4'd3;
        set_load_use();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect3(idle, idle, idle);
        check_pop("reset_outputs");
        for (int g = 0; g < 3; g++) begin
            check_val("reset_stall_cnt", g, stall_cnt[g], 32'd0);
            check_val("reset_flush_cnt", g, flush_cnt[g], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            ra1e = vecs[i].ra1e; ra2e = vecs[i].ra2e;
            wa3m = vecs[i].wa3m; wa3w = vecs[i].wa3w;
            rwm  = vecs[i].rwm;  rww  = vecs[i].rww;
            fa = vecs[i].fa; fb = vecs[i].fb;
            cyc("fwd_table", mk(S_RUN, fa, fb, 0, 0, 0, 0), mk(S_RUN, fa, fb, 0, 0, 0, 0),
                mk(S_RUN, fa, fb, 0, 0, 0, 0));
        end
        clear_inputs();

        for (int i = 0; i < 24; i++) begin
            ra1e = 4'($urandom_range(0, 3)); ra2e = 4'($urandom_range(0, 3));
            wa3m = 4'($urandom_range(0, 3)); wa3w = 4'($urandom_range(0, 3));
            rwm  = 1'($urandom_range(0, 1)); rww  = 1'($urandom_range(0, 1));
            ra1d = 4'($urandom_range(0, 15)); ra2d = 4'($urandom_range(0, 15));
            fa = ref_fwd(ra1e, wa3m, rwm, wa3w, rww);
            fb = ref_fwd(ra2e, wa3m, rwm, wa3w, rww);
            cyc("fwd_random", mk(S_RUN, fa, fb, 0, 0, 0, 0), mk(S_RUN, fa, fb, 0, 0, 0, 0),
                mk(S_RUN, fa, fb, 0, 0, 0, 0));
        end
        clear_inputs();

        // Near-misses for load-use: not a register write, then no address match.
        m2re = 1; rwe = 0; wa3e = 4'd5; ra2d = 4'd5;
        cyc("lu_no_regwrite", idle, idle, idle);
        rwe = 1; ra2d = 4'd6; ra1d = 4'd7;
        cyc("lu_no_match", idle, idle, idle);
        m2re = 1; rwe = 1; wa3e = 4'd0; ra1d = 4'd0; ra2d = 4'd9;
        cyc("lu_reg0", lu, lu, lu);
        clear_inputs();
        cyc("lu_reg0_c1", idle, lw, lw);
        cyc("lu_reg0_c2", idle, lw, lw);
        cyc("lu_reg0_c3", idle, idle, lw);
        cyc("lu_reg0_c4", idle, idle, idle);

        lu_seq("lu");

        // PC-write serialisation; load-use during PC_WAIT must be ignored.
        pcd = 1;
        cyc("pc_c0", idle, idle, idle);
        pcd = 0; pce = 1;
        cyc("pc_c1", pcw_w, pcw_w, pcw_w);
        pce = 0; pcm = 1; rwm = 1; wa3m = 4'd2; ra1e = 4'd2;
        set_load_use();
        cyc("pc_c2", mk(S_PC, 2'b10, 2'b00, 1, 0, 1, 0), mk(S_PC, 2'b10, 2'b00, 1, 0, 1, 0),
            mk(S_PC, 2'b10, 2'b00, 1, 0, 1, 0));
        clear_inputs();
        pcw = 1;
        cyc("pc_c3", pcw_w, pcw_w, pcw_w);
        pcw = 0;
        cyc("pc_c4", idle, idle, idle);

        // Branch on the second bubble cycle of a load stall.
        for (int g = 0; g < 3; g++) base[g] = flush_cnt[g];
        set_load_use();
        cyc("br_lw_c0", lu, lu, lu);
        clear_inputs();
        bte = 1;
        cyc("br_lw_c1", br_run, br_lw, br_lw);
        bte = 0;
        cyc("br_lw_c2", idle, idle, idle);
        for (int g = 0; g < 3; g++) begin
`ifdef HAZARD_PERF_CNT_EN
            check_val("br_flush_cnt", g, flush_cnt[g] - base[g], 32'd1);
`else
            check_val("br_flush_cnt", g, flush_cnt[g], 32'd0);
`endif
        end
        lu_seq("lu_after_br");

        // Branch aborting PC_WAIT, and branch beating a simultaneous load-use.
        pcd = 1;
        cyc("br_pc_c0", idle, idle, idle);
        pcd = 0; bte = 1;
        cyc("br_pc_c1", br_pc, br_pc, br_pc);
        bte = 0;
        cyc("br_pc_c2", idle, idle, idle);
        set_load_use();
        bte = 1;
        cyc("br_lu_c0", br_run, br_run, br_run);
        clear_inputs();
        cyc("br_lu_c1", idle, idle, idle);

        // Asynchronous reset in the middle of PC_WAIT.
        pcd = 1;
        cyc("rst_pc_c0", idle, idle, idle);
        pcd = 0; rwm = 1; wa3m = 4'd6; ra1e = 4'd6;
        cyc("rst_pc_c1", mk(S_PC, 2'b10, 2'b00, 1, 0, 1, 0), mk(S_PC, 2'b10, 2'b00, 1, 0, 1, 0),
            mk(S_PC, 2'b10, 2'b00, 1, 0, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        expect3(idle, idle, idle);
        check_pop("rst_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("post_reset", mk(S_RUN, 2'b10, 2'b00, 0, 0, 0, 0), mk(S_RUN, 2'b10, 2'b00, 0, 0, 0, 0),
            mk(S_RUN, 2'b10, 2'b00, 0, 0, 0, 0));
        for (int g = 0; g < 3; g++) begin
            check_val("post_reset_stall_cnt", g, stall_cnt[g], 32'd0);
            check_val("post_reset_flush_cnt", g, flush_cnt[g], 32'd0);
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
